// File: rtl/instr_pair_splitter.sv
// Deals an in-order instruction stream round-robin into two FWFT queues (even -> q0, odd -> q1).
// Optional statistics outputs (pop_count, hwm) are built when INSTR_Q_STATS_EN is defined.
module instr_pair_splitter #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               en_out0,
    output logic [INSTR_W-1:0] instr_out0,
    input  logic               en_ack0,
    output logic               en_out1,
    output logic [INSTR_W-1:0] instr_out1,
    input  logic               en_ack1,
    output logic [ADDR_W:0]    q0_count,
    output logic [ADDR_W:0]    q1_count,
    output logic               idle
`ifdef INSTR_Q_STATS_EN
    ,
    output logic [31:0]        pop_count,
    output logic [ADDR_W:0]    hwm
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic                wsel_q, wsel_d;
    logic [ADDR_W:0]     count_q  [2];
    logic [ADDR_W:0]     count_d  [2];
    logic [ADDR_W-1:0]   wr_ptr_q [2];
    logic [ADDR_W-1:0]   wr_ptr_d [2];
    logic [ADDR_W-1:0]   rd_ptr_q [2];
    logic [ADDR_W-1:0]   rd_ptr_d [2];
    logic [1:0]          push, pop, ack, head_load, bypass;
    logic                active, accept;
    logic [INSTR_W-1:0]  mem0 [DEPTH];
    logic [INSTR_W-1:0]  mem1 [DEPTH];
    logic [INSTR_W-1:0]  head0_q, head1_q;

    assign ack = {en_ack1, en_ack0};

    always_comb begin
        active   = rst_n & ~flush;
        in_ready = active & (count_q[wsel_q] != FULL_CNT);
        accept   = in_valid & in_ready;
        push     = {accept & wsel_q, accept & ~wsel_q};
        wsel_d   = active ? (wsel_q ^ accept) : 1'b0;
        for (int q = 0; q < 2; q++) begin
            pop[q]      = active & (count_q[q] != '0) & ack[q];
            count_d[q]  = count_q[q] + (ADDR_W+1)'(push[q]) - (ADDR_W+1)'(pop[q]);
            wr_ptr_d[q] = wr_ptr_q[q] + ADDR_W'(push[q]);
            rd_ptr_d[q] = rd_ptr_q[q] + ADDR_W'(pop[q]);
            // The pushed word is the next head when the queue is (or becomes) empty this cycle.
            bypass[q]    = push[q] & (count_q[q] == (ADDR_W+1)'(pop[q]));
            head_load[q] = (pop[q] | (push[q] & (count_q[q] == '0))) & (count_d[q] != '0);
            if (!active) begin
                count_d[q]   = '0;
                wr_ptr_d[q]  = '0;
                rd_ptr_d[q]  = '0;
                head_load[q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wsel_q <= 1'b0;
            for (int q = 0; q < 2; q++) begin
                count_q[q]  <= '0;
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
            end
        end else begin
            wsel_q <= wsel_d;
            for (int q = 0; q < 2; q++) begin
                count_q[q]  <= count_d[q];
                wr_ptr_q[q] <= wr_ptr_d[q];
                rd_ptr_q[q] <= rd_ptr_d[q];
            end
        end
    end

    // Head registers double as the RAM read registers; they hold while a queue is empty.
    always_ff @(posedge clk) begin
        if (push[0]) mem0[wr_ptr_q[0]] <= in_instr;
        if (head_load[0]) head0_q <= bypass[0] ? in_instr : mem0[rd_ptr_d[0]];
    end

    always_ff @(posedge clk) begin
        if (push[1]) mem1[wr_ptr_q[1]] <= in_instr;
        if (head_load[1]) head1_q <= bypass[1] ? in_instr : mem1[rd_ptr_d[1]];
    end

    assign en_out0    = (count_q[0] != '0);
    assign en_out1    = (count_q[1] != '0);
    assign instr_out0 = head0_q;
    assign instr_out1 = head1_q;
    assign q0_count   = count_q[0];
    assign q1_count   = count_q[1];
    assign idle       = (count_q[0] == '0) & (count_q[1] == '0) & ~in_valid;

`ifdef INSTR_Q_STATS_EN
    logic [31:0]     pop_count_q, pop_count_d;
    logic [ADDR_W:0] hwm_q, hwm_d;

    always_comb begin
        pop_count_d = pop_count_q + 32'(pop[0]) + 32'(pop[1]);
        hwm_d       = hwm_q;
        if (count_q[0] > hwm_d) hwm_d = count_q[0];
        if (count_q[1] > hwm_d) hwm_d = count_q[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_count_q <= '0;
            hwm_q       <= '0;
        end else begin
            pop_count_q <= pop_count_d;
            hwm_q       <= hwm_d;
        end
    end

    assign pop_count = pop_count_q;
    assign hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_instr_pair_splitter.sv
// Randomized scoreboard bench for instr_pair_splitter with a small (depth-4) queue build.
module tb_instr_pair_splitter;
    localparam int AW    = 2;
    localparam int IW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic          en_ack0 = 1'b0, en_ack1 = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic          in_ready, en_out0, en_out1, idle;
    logic [IW-1:0] instr_out0, instr_out1;
    logic [AW:0]   q0_count, q1_count;
`ifdef INSTR_Q_STATS_EN
    logic [31:0]   pop_count;
    logic [AW:0]   hwm;
`endif

    instr_pair_splitter #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .en_out0(en_out0), .instr_out0(instr_out0), .en_ack0(en_ack0),
        .en_out1(en_out1), .instr_out1(instr_out1), .en_ack1(en_ack1),
        .q0_count(q0_count), .q1_count(q1_count), .idle(idle)
`ifdef INSTR_Q_STATS_EN
        , .pop_count(pop_count), .hwm(hwm)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: two plain queues of words, a round-robin selector and last-seen heads.
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    bit          wsel_m = 1'b0, rdy_m = 1'b0, lh0_v = 1'b0, lh1_v = 1'b0;
    logic [31:0] lh0 = '0, lh1 = '0;
    int          s0, s1;
    int          n_checks = 0, n_fail = 0;
    int unsigned pc_m = 0;
    int          hwm_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model and retires popped words.
    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_m = 1'b0;
            chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        end else begin
            s0 = exp0.size();
            s1 = exp1.size();
            rdy_m = !flush && ((wsel_m ? s1 : s0) < DEPTH);
            chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_m});
            chk("q0_count", 64'(q0_count), 64'(s0));
            chk("q1_count", 64'(q1_count), 64'(s1));
            chk("en_out0", {63'd0, en_out0}, {63'd0, s0 > 0});
            chk("en_out1", {63'd0, en_out1}, {63'd0, s1 > 0});
            if (s0 > 0) begin
                chk("instr_out0", 64'(instr_out0), 64'(exp0[0]));
                lh0 = exp0[0]; lh0_v = 1'b1;
            end else if (lh0_v) chk("instr_out0_hold", 64'(instr_out0), 64'(lh0));
            if (s1 > 0) begin
                chk("instr_out1", 64'(instr_out1), 64'(exp1[0]));
                lh1 = exp1[0]; lh1_v = 1'b1;
            end else if (lh1_v) chk("instr_out1_hold", 64'(instr_out1), 64'(lh1));
            chk("idle", {63'd0, idle}, {63'd0, (s0 == 0) && (s1 == 0) && !in_valid});
`ifdef INSTR_Q_STATS_EN
            chk("pop_count", 64'(pop_count), 64'(pc_m));
            chk("hwm", 64'(hwm), 64'(hwm_m));
            if (s0 > hwm_m) hwm_m = s0;
            if (s1 > hwm_m) hwm_m = s1;
`endif
            if (!flush) begin
                if (s0 > 0 && en_ack0) begin void'(exp0.pop_front()); pc_m++; end
                if (s1 > 0 && en_ack1) begin void'(exp1.pop_front()); pc_m++; end
            end
        end
    end

    // Stimulus side of the scoreboard: accepted words are queued as expected results.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            exp0.delete(); exp1.delete();
            wsel_m = 1'b0; lh0_v = 1'b0; lh1_v = 1'b0; pc_m = 0; hwm_m = 0;
        end else if (flush) begin
            exp0.delete(); exp1.delete();
            wsel_m = 1'b0;
        end else if (in_valid && rdy_m) begin
            if (wsel_m) exp1.push_back(in_instr);
            else        exp0.push_back(in_instr);
            wsel_m = ~wsel_m;
        end
    end

    task automatic drive(input bit v, input logic [31:0] d, input bit a0, input bit a1, input bit fl);
        in_valid = v; in_instr = d; en_ack0 = a0; en_ack1 = a1; flush = fl;
        @(posedge clk);
        #1;
    endtask

    bit rs;
    int phase;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) drive(1, 32'hA000_0000 + i, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 1, 0);

        for (int i = 0; i < 9; i++) drive(1, 32'hB000_0000 + i, 0, 0, 0);
        drive(1, 32'hB000_0008, 1, 0, 0);
        drive(1, 32'hB000_0008, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 1, 1, 0);

        for (int i = 0; i < 4; i++) drive(1, 32'hC000_0000 + i, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 1);
        drive(1, 32'hD000_0000, 0, 0, 0);
        drive(1, 32'hD000_0001, 0, 0, 0);
        drive(1, 32'hD000_0002, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 32'hE000_0000 + i, 0, 0, 0);
        drive(1, 32'hE000_0005, 0, 0, 1);
        drive(1, 32'hE000_0006, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 499) == 0);
            if (rs) begin
                rst_n = 1'b0;
                drive(0, 0, 0, 0, 0);
                rst_n = 1'b1;
            end else begin
                phase = (c / 400) % 4;
                drive($urandom_range(0, 9) < 7, $urandom,
                      $urandom_range(0, 3) <= phase, $urandom_range(0, 3) <= 3 - phase,
                      $urandom_range(0, 99) == 0);
            end
        end
        repeat (20) drive(0, 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
